// File: rtl/imem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter_if
//   Bundles the fetch port, the loader/debug port and the IMEM array port that
//   meet at imem_port_arbiter.
//   slave  : arbiter side (takes requests, drives grants/responses and mem_*)
//   master : environment side (fetch stage, loader and the IMEM array)
//   Signals:
//     fetch  : f_req, f_addr, f_flush -> f_gnt, f_rvalid, f_rdata, f_err
//     loader : l_req, l_we, l_addr, l_wdata -> l_gnt, l_rvalid, l_rdata, l_err
//     memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle latency)
// -----------------------------------------------------------------------------
interface imem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_AW    = 18
);
  // fetch port
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_flush;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_err;
  // loader / debug port
  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_gnt;
  logic                  l_rvalid;
  logic [DATA_WIDTH-1:0] l_rdata;
  logic                  l_err;
  // memory port
  logic                  mem_en;
  logic                  mem_we;
  logic [WORD_AW-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//   Shares one single-port synchronous IMEM between the CPU fetch port
//   (read-only) and the loader/debug port (read/write). At most one access is
//   issued per cycle; every granted address is checked for word alignment and
//   range. Responses come back exactly one cycle after the grant. A wait
//   counter lets a starved loader preempt fetch after MAX_WAIT denied cycles.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active-high
//     bus  : imem_port_arbiter_if.slave (fetch, loader and memory signals)
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_AW    = 18,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_port_arbiter_if.slave bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_cnt_nxt;

  logic f_win;
  logic l_win;
  logic f_bad;
  logic l_bad;
  logic good_acc;

  // response-stage flags, captured at grant time
  logic rsp_f;
  logic rsp_l;
  logic rsp_err;
  logic rsp_rd;

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_WIDTH-1:WORD_AW+2] != '0);
  endfunction

  // Grant decision. Gated by rst so every output reads 0 while reset is held,
  // even though grants are otherwise purely combinational from the requests.
  always_comb begin
    l_win = 1'b0;
    f_win = 1'b0;
    if (!rst) begin
      l_win = bus.l_req && (!bus.f_req || (wait_cnt == WAIT_MAX));
      f_win = bus.f_req && !l_win;
    end
  end

  assign f_bad    = addr_bad(bus.f_addr);
  assign l_bad    = addr_bad(bus.l_addr);
  assign good_acc = (f_win && !f_bad) || (l_win && !l_bad);

  assign bus.f_gnt = f_win;
  assign bus.l_gnt = l_win;

  // Memory request. A faulting grant still wins arbitration but never touches
  // the array.
  always_comb begin
    bus.mem_en    = good_acc;
    bus.mem_we    = l_win && !l_bad && bus.l_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (f_win) begin
      bus.mem_addr = bus.f_addr[WORD_AW+1:2];
    end else if (l_win) begin
      bus.mem_addr  = bus.l_addr[WORD_AW+1:2];
      bus.mem_wdata = bus.l_wdata;
    end
  end

  // Starvation counter: counts consecutive denied loader cycles, saturating so
  // the preempt condition stays true until the loader is served.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!bus.l_req || l_win) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_nxt = wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      rsp_f    <= 1'b0;
      rsp_l    <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_rd   <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      rsp_f    <= f_win;
      rsp_l    <= l_win;
      rsp_err  <= (f_win && f_bad) || (l_win && l_bad);
      rsp_rd   <= good_acc && !(l_win && bus.l_we);
    end
  end

  // Response stage. Read data is passed straight through from the array in
  // the cycle it appears; writes and faults return zero. f_flush only masks
  // the fetch response, the pipeline state itself is untouched.
  always_comb begin
    bus.f_rvalid = rsp_f && !bus.f_flush;
    bus.f_err    = rsp_f && !bus.f_flush && rsp_err;
    bus.f_rdata  = '0;
    if (rsp_f && !bus.f_flush && rsp_rd) begin
      bus.f_rdata = bus.mem_rdata;
    end

    bus.l_rvalid = rsp_l;
    bus.l_err    = rsp_l && rsp_err;
    bus.l_rdata  = '0;
    if (rsp_l && rsp_rd) begin
      bus.l_rdata = bus.mem_rdata;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(bus.f_gnt && bus.l_gnt));
  a_we_needs_en: assert property (@(posedge clk) disable iff (rst) bus.mem_we |-> bus.mem_en);

endmodule
